mult_ctrl: RTL and testbench
============================

MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter LATENCY, default 8: cycles spent in WAIT after m_start is sampled; legal range 7..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
REQ-004 op_valid  input  1  CPU presents an operation this cycle.
REQ-005 op  input  2  00 MULT (signed), 01 MULTU, 10 MTHI, 11 MTLO.
REQ-006 op_a  input  32  multiplicand, or write data for MTHI/MTLO.
REQ-007 op_b  input  32  multiplier operand; ignored for MTHI/MTLO.
REQ-008 op_ready  output  1  high only in IDLE; an op is accepted on a rising edge when op_valid && op_ready.
REQ-009 rd_req  input  1  CPU is executing MFHI/MFLO this cycle.
REQ-010 stall  output  1  combinational: rd_req && state != IDLE.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.
REQ-013 m_start  output  1  single-cycle start pulse to the multiplier.
REQ-014 m_signed  output  1  held signedness to the multiplier.
REQ-015 m_a, m_b  output  32 each  held operands to the multiplier.
REQ-016 m_z  input  64  multiplier product.
REQ-017 m_busy  input  1  multiplier busy flag.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and WRITE, with a 4-bit cycle counter cnt.
REQ-019 In IDLE, accepting MULT/MULTU SHALL register m_a=op_a, m_b=op_b and m_signed=(op==00), then go to ISSUE.
REQ-020 In IDLE, accepting MTHI (or MTLO) SHALL write op_a into hi (or lo) on that edge and stay in IDLE; the other register is unchanged.
REQ-021 ISSUE SHALL last exactly one cycle with m_start=1, then go to WAIT with cnt=0; m_start SHALL be 0 in every other state.
REQ-022 In WAIT, cnt SHALL increment every cycle, and the FSM SHALL go to WRITE on the edge where cnt >= LATENCY-1 and m_busy==0; otherwise it stays in WAIT, with cnt saturating at 15.
REQ-023 WRITE SHALL last one cycle, load {hi,lo}=m_z on its closing edge, then return to IDLE.
REQ-024 m_a, m_b and m_signed SHALL be held stable from ISSUE through WRITE, because the multiplier uses them at its output stage.
REQ-025 Latency: with acceptance at edge E0 and m_busy low in time, hi/lo SHALL hold the product after edge E(LATENCY+2) (E10 by default), and op_ready SHALL be high again in the cycle after that edge.
REQ-026 op_valid outside IDLE SHALL be ignored (op_ready=0), with no side effects; the CPU holds the op.
REQ-027 rd_req in IDLE SHALL give stall=0; hi/lo show registered values, so an MFHI in the same cycle as an accepted MTHI reads the old HI.
REQ-028 rd_req in ISSUE, WAIT or WRITE SHALL give stall=1; stall deasserts in the cycle after the WRITE edge, when hi/lo are already updated.
REQ-029 Back-to-back MULTs SHALL be separated by at least one IDLE cycle, and no second m_start SHALL be issued while in WAIT.
REQ-030 Product arithmetic is delegated to the multiplier; the controller SHALL not modify m_z, writing hi=m_z[63:32] and lo=m_z[31:0].

Reset
REQ-031 When rst_n=0, the block SHALL set state=IDLE, cnt=0, hi=0, lo=0, m_start=0, m_signed=0, m_a=0 and m_b=0 immediately (asynchronously).
REQ-032 Reset mid-operation (ISSUE/WAIT/WRITE) SHALL abandon the multiply and leave hi/lo at 0; op_ready SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-033 MULTU with op_a=op_b=0xFFFFFFFF -> one m_start pulse one cycle after acceptance, then hi=0xFFFFFFFE and lo=0x00000001 after E10.
REQ-034 MULT with op_a=0xFFFFFFFE (-2) and op_b=3 -> hi=0xFFFFFFFF and lo=0xFFFFFFFA; MULT with -1*-1 -> hi=0 and lo=1.
REQ-035 MULT accepted, rd_req held high -> stall=1 through the WRITE cycle and 0 in the next cycle, with hi/lo showing the new product in that cycle.
REQ-036 MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi=0x12345678 and lo=0x9ABCDEF0; rd_req in the MTHI cycle sees old HI with stall=0.
REQ-037 op_valid MULT held during WAIT with different operands -> not accepted, and m_a/m_b unchanged until after WRITE.
REQ-038 rst_n pulsed low in WAIT cnt=3 -> immediately state IDLE, hi=lo=0, m_start=0, and no later hi/lo update.

Source files
------------

// File: rtl/mult_ctrl_if.sv
// CPU-side bus of the HI/LO multiply controller: op issue handshake, MFHI/MFLO
// stall, and the architectural HI/LO values.
interface mult_ctrl_if;
  logic        op_valid;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        rd_req;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid,
    output op,
    output op_a,
    output op_b,
    output rd_req,
    input  op_ready,
    input  stall,
    input  hi,
    input  lo
  );

  modport slave (
    input  op_valid,
    input  op,
    input  op_a,
    input  op_b,
    input  rd_req,
    output op_ready,
    output stall,
    output hi,
    output lo
  );
endinterface

// File: rtl/mult_ctrl.sv
// Sequences MULT/MULTU through an external multiplier and owns the HI/LO
// registers; MTHI/MTLO write them directly while idle.
module mult_ctrl #(
  parameter int unsigned LATENCY = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_ctrl_if.slave  cpu,
  output logic        m_start_o,
  output logic        m_signed_o,
  output logic [31:0] m_a_o,
  output logic [31:0] m_b_o,
  input  logic [63:0] m_z_i,
  input  logic        m_busy_i
);

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpMthi  = 2'b10;
  localparam logic [1:0] OpMtlo  = 2'b11;

  localparam logic [3:0] CntDone = 4'(LATENCY - 1);
  localparam logic [3:0] CntMax  = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        m_start_q;
  logic        m_signed_q;
  logic [31:0] m_a_q;
  logic [31:0] m_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_start_q  <= 1'b0;
      m_signed_q <= 1'b0;
      m_a_q      <= '0;
      m_b_q      <= '0;
    end else begin
      m_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu.op_valid) begin
            unique case (cpu.op)
              OpMult, OpMultu: begin
                m_a_q      <= cpu.op_a;
                m_b_q      <= cpu.op_b;
                m_signed_q <= (cpu.op == OpMult);
                m_start_q  <= 1'b1;
                state_q    <= StIssue;
              end
              OpMthi: hi_q <= cpu.op_a;
              OpMtlo: lo_q <= cpu.op_a;
            endcase
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 4'd1;
          end
          // Minimum latency elapsed and the multiplier reports its product valid.
          if (cnt_q >= CntDone && !m_busy_i) begin
            state_q <= StWrite;
          end
        end
        StWrite: begin
          hi_q    <= m_z_i[63:32];
          lo_q    <= m_z_i[31:0];
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu.op_ready = (state_q == StIdle);
  assign cpu.stall    = cpu.rd_req && (state_q != StIdle);
  assign cpu.hi       = hi_q;
  assign cpu.lo       = lo_q;

  assign m_start_o  = m_start_q;
  assign m_signed_o = m_signed_q;
  assign m_a_o      = m_a_q;
  assign m_b_o      = m_b_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Randomised bench for mult_ctrl: a behavioural multiplier with a variable busy
// window drives m_z, and a HI/LO reference model predicts every cycle.
module tb_mult_ctrl;
  localparam int unsigned Latency = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_ctrl_if cpu_if ();

  logic        m_start;
  logic        m_signed;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [63:0] m_z;
  logic        m_busy;

  mult_ctrl #(
    .LATENCY (Latency)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (cpu_if),
    .m_start_o  (m_start),
    .m_signed_o (m_signed),
    .m_a_o      (m_a),
    .m_b_o      (m_b),
    .m_z_i      (m_z),
    .m_busy_i   (m_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    return ea * eb;
  endfunction

  // Multiplier model: busy for busy_len cycles after a start; garbage while busy.
  int unsigned busy_len = 0;
  int unsigned busy_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (m_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign m_busy = (busy_cnt != 0);
  assign m_z    = m_busy ? 64'hBAD0_BAD0_BAD0_BAD0 : mul_ref(m_signed, m_a, m_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int unsigned blen, input bit noisy);
    int unsigned done;
    logic [63:0] prod;
    logic        sgn;
    sgn      = (op == 2'b00);
    prod     = mul_ref(sgn, a, b);
    done     = (blen + 3 > Latency + 2) ? blen + 3 : Latency + 2;
    busy_len = blen;
    cpu_if.op_valid = 1'b1;
    cpu_if.op       = op;
    cpu_if.op_a     = a;
    cpu_if.op_b     = b;
    cpu_if.rd_req   = 1'($urandom);
    #1;
    check("ready_before", cpu_if.op_ready, 1'b1);
    check("stall_idle", cpu_if.stall, 1'b0);
    step();
    for (int unsigned k = 0; k <= done; k++) begin
      if (noisy && k < done) begin
        cpu_if.op_valid = 1'b1;
        cpu_if.op       = 2'($urandom);
        cpu_if.op_a     = $urandom;
        cpu_if.op_b     = $urandom;
      end else begin
        cpu_if.op_valid = 1'b0;
      end
      cpu_if.rd_req = 1'($urandom);
      #1;
      check("m_start", m_start, k == 0);
      check("op_ready", cpu_if.op_ready, k >= done);
      check("stall", cpu_if.stall, cpu_if.rd_req && (k < done));
      if (k < done) begin
        check("m_a_hold", m_a, a);
        check("m_b_hold", m_b, b);
        check("m_signed_hold", m_signed, sgn);
        check("hi_old", cpu_if.hi, exp_hi);
        check("lo_old", cpu_if.lo, exp_lo);
        step();
      end else begin
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        check("hi_new", cpu_if.hi, exp_hi);
        check("lo_new", cpu_if.lo, exp_lo);
      end
    end
    cpu_if.op_valid = 1'b0;
    cpu_if.rd_req   = 1'b0;
  endtask

  task automatic mt_pair(input logic [31:0] hv, input logic [31:0] lv);
    cpu_if.op_valid = 1'b1;
    cpu_if.op       = 2'b10;
    cpu_if.op_a     = hv;
    cpu_if.op_b     = $urandom;
    cpu_if.rd_req   = 1'b1;
    #1;
    check("mthi_stall", cpu_if.stall, 1'b0);
    check("mthi_old_hi", cpu_if.hi, exp_hi);
    step();
    exp_hi = hv;
    cpu_if.op   = 2'b11;
    cpu_if.op_a = lv;
    #1;
    check("mthi_hi", cpu_if.hi, exp_hi);
    check("mthi_lo_kept", cpu_if.lo, exp_lo);
    check("mt_ready", cpu_if.op_ready, 1'b1);
    step();
    exp_lo = lv;
    cpu_if.op_valid = 1'b0;
    cpu_if.rd_req   = 1'b0;
    #1;
    check("mtlo_lo", cpu_if.lo, exp_lo);
    check("mtlo_hi_kept", cpu_if.hi, exp_hi);
  endtask

  initial begin
    cpu_if.op_valid = 1'b0;
    cpu_if.op       = 2'b00;
    cpu_if.op_a     = '0;
    cpu_if.op_b     = '0;
    cpu_if.rd_req   = 1'b0;
    step();
    step();
    check("rst_hi", cpu_if.hi, 32'h0);
    check("rst_lo", cpu_if.lo, 32'h0);
    check("rst_m_start", m_start, 1'b0);
    check("rst_m_a", m_a, 32'h0);
    check("rst_m_b", m_b, 32'h0);
    check("rst_m_signed", m_signed, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_ready", cpu_if.op_ready, 1'b1);

    run_mult(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_max_hi", cpu_if.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", cpu_if.lo, 32'h0000_0001);
    run_mult(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 2, 1'b0);
    check("mult_m2x3_hi", cpu_if.hi, 32'hFFFF_FFFF);
    check("mult_m2x3_lo", cpu_if.lo, 32'hFFFF_FFFA);
    run_mult(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
    check("mult_m1xm1_hi", cpu_if.hi, 32'h0);
    check("mult_m1xm1_lo", cpu_if.lo, 32'h1);
    mt_pair(32'h1234_5678, 32'h9ABC_DEF0);
    check("mt_dir_hi", cpu_if.hi, 32'h1234_5678);
    check("mt_dir_lo", cpu_if.lo, 32'h9ABC_DEF0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        mt_pair($urandom, $urandom);
      end else begin
        run_mult(2'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 12),
                 1'($urandom));
      end
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset during WAIT with cnt=3 (four edges after the acceptance edge).
    busy_len        = 0;
    cpu_if.op_valid = 1'b1;
    cpu_if.op       = 2'b01;
    cpu_if.op_a     = 32'hDEAD_BEEF;
    cpu_if.op_b     = 32'h0000_1234;
    step();
    cpu_if.op_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("arst_ready", cpu_if.op_ready, 1'b1);
    check("arst_hi", cpu_if.hi, exp_hi);
    check("arst_lo", cpu_if.lo, exp_lo);
    check("arst_m_start", m_start, 1'b0);
    check("arst_m_a", m_a, 32'h0);
    step();
    rst_n = 1'b1;
    cpu_if.rd_req = 1'b1;
    step();
    check("arst_ready_after", cpu_if.op_ready, 1'b1);
    check("arst_stall_after", cpu_if.stall, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step();
      check("arst_no_start", m_start, 1'b0);
      check("arst_hi_hold", cpu_if.hi, exp_hi);
      check("arst_lo_hold", cpu_if.lo, exp_lo);
    end
    cpu_if.rd_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
